// File: rtl/gcm_result_streamer.sv
// gcm_result_streamer: captures the GCM ciphertext and tag on their ready edges and
// streams them as one OUT_W-bit valid/ready frame (ciphertext beats, then tag beats).
module gcm_result_streamer #(
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             i_reset_n,
  input  logic             i_cp_ready,
  input  logic [0:127]     i_cipher_text,
  input  logic             i_tag_ready,
  input  logic [0:127]     i_tag,
  output logic [OUT_W-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_last,
  output logic             o_busy,
  output logic             o_overrun
);
  localparam int NBEATS = 128 / OUT_W;
  localparam int BW = $clog2(NBEATS);
  typedef enum logic [1:0] {IDLE, SEND_CT, WAIT_TAG, SEND_TAG} state_t;
  state_t state_q, state_d;
  logic cp_q, tag_q, pend_q, pend_d, ovr_q, ovr_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [0:127] ct_q, ct_d, tg_q, tg_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic valid_q, valid_d, last_q, last_d;
  logic cp_rise, tag_rise, tag_block, accept, final_beat;
  assign cp_rise    = i_cp_ready & ~cp_q;
  assign tag_rise   = i_tag_ready & ~tag_q;
  assign tag_block  = pend_q || state_q == SEND_TAG;
  assign accept     = valid_q && i_ready;
  assign final_beat = beat_q == BW'(NBEATS - 1);
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    ct_d    = ct_q;
    tg_d    = tg_q;
    pend_d  = pend_q;
    ovr_d   = ovr_q | (cp_rise && state_q != IDLE) | (tag_rise && tag_block);
    if (tag_rise && !tag_block) begin
      tg_d   = i_tag;
      pend_d = 1'b1;
    end
    unique case (state_q)
      IDLE:
        if (cp_rise) begin
          state_d = SEND_CT;
          beat_d  = '0;
          ct_d    = i_cipher_text;
        end
      SEND_CT:
        if (accept) begin
          beat_d = final_beat ? '0 : beat_q + BW'(1);
          if (final_beat) state_d = pend_d ? SEND_TAG : WAIT_TAG;
        end
      WAIT_TAG:
        if (pend_d) state_d = SEND_TAG;
      SEND_TAG:
        if (accept) begin
          beat_d = final_beat ? '0 : beat_q + BW'(1);
          if (final_beat) begin
            state_d = IDLE;
            pend_d  = 1'b0;
          end
        end
      default: state_d = IDLE;
    endcase
    // outputs are registered from next-state values so beat 0 appears the cycle after the edge
    valid_d = state_d == SEND_CT || state_d == SEND_TAG;
    data_d  = state_d == SEND_CT  ? ct_d[int'(beat_d) * OUT_W +: OUT_W] :
              state_d == SEND_TAG ? tg_d[int'(beat_d) * OUT_W +: OUT_W] : '0;
    last_d  = state_d == SEND_TAG && beat_d == BW'(NBEATS - 1);
  end
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      cp_q    <= 1'b0;
      tag_q   <= 1'b0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
      beat_q  <= '0;
      ct_q    <= '0;
      tg_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cp_q    <= i_cp_ready;
      tag_q   <= i_tag_ready;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      beat_q  <= beat_d;
      ct_q    <= ct_d;
      tg_q    <= tg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end
  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_last    = last_q;
  assign o_busy    = state_q != IDLE || pend_q;
  assign o_overrun = ovr_q;
endmodule

// File: tb/tb_gcm_result_streamer.sv
// tb_gcm_result_streamer: randomized frame bench; expected beats come from a byte queue
// built directly from each ciphertext/tag pair that should be streamed.
module tb_gcm_result_streamer;
  logic clk = 0, rst_n = 0, cp = 0, tg = 0, rdy = 1;
  logic [0:127] ct_in = '0, tag_in = '0;
  logic [0:127] ctv = 128'h0388dace60b6a392f328c2b971b2fe78;
  logic [0:127] tagv = 128'hab6e47d42cec13bdf53a67b21257bddf;
  logic [0:127] ffv = '1;
  logic [0:127] rc, rt;
  logic [7:0] d8, prev_d;
  logic v8, l8, b8, ov8;
  logic [31:0] d32;
  logic v32, l32, b32, ov32;
  int checks = 0, errors = 0, n;
  logic [8:0] exp_q[$];
  logic [8:0] e;
  logic [32:0] got32[$];
  bit col32 = 0, rnd_rdy = 0, prev_stall = 0;
  always #5 clk = ~clk;
  gcm_result_streamer #(.OUT_W(8)) dut (
    .clk(clk), .i_reset_n(rst_n), .i_cp_ready(cp), .i_cipher_text(ct_in),
    .i_tag_ready(tg), .i_tag(tag_in), .o_data(d8), .o_valid(v8), .i_ready(rdy),
    .o_last(l8), .o_busy(b8), .o_overrun(ov8)
  );
  gcm_result_streamer #(.OUT_W(32)) dut32 (
    .clk(clk), .i_reset_n(rst_n), .i_cp_ready(cp), .i_cipher_text(ct_in),
    .i_tag_ready(tg), .i_tag(tag_in), .o_data(d32), .o_valid(v32), .i_ready(1'b1),
    .o_last(l32), .o_busy(b32), .o_overrun(ov32)
  );
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic push_frame(input logic [0:127] c, input logic [0:127] t);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b0, c[i*8 +: 8]});
    for (int i = 0; i < 16; i++) exp_q.push_back({i == 15, t[i*8 +: 8]});
  endtask
  task automatic drive_cp(input logic [0:127] c);
    @(posedge clk); #1 ct_in = c; cp = 1;
  endtask
  task automatic drive_tag(input logic [0:127] t);
    @(posedge clk); #1 tag_in = t; tg = 1;
  endtask
  task automatic drop();
    @(posedge clk); #1 cp = 0; tg = 0;
  endtask
  task automatic wait_drain();
    int k = 0;
    while ((b8 || exp_q.size() != 0) && k < 3000) begin @(negedge clk); #1; k++; end
    check("drained", {b8, exp_q.size() != 0}, 2'b00);
  endtask
  always @(posedge clk) begin
    #1 rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  always @(negedge clk) begin
    if (!rst_n) prev_stall = 0;
    else begin
      if (prev_stall) begin
        check("hold_valid", v8, 1'b1);
        check("hold_data", d8, prev_d);
      end
      if (v8 && rdy) begin
        check("beat_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("beat_data", d8, e[7:0]);
          check("beat_last", l8, e[8]);
        end
      end
      prev_stall = v8 && !rdy;
      prev_d = d8;
      if (col32 && v32) got32.push_back({l32, d32});
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid", v8, 0);
    check("rst_last", l8, 0);
    check("rst_busy", b8, 0);
    check("rst_ovr", ov8, 0);
    check("rst_data", d8, 0);
    @(posedge clk); #1 rst_n = 1;
    // known vectors, ready held high, both widths
    col32 = 1;
    push_frame(ctv, tagv);
    drive_cp(ctv);
    @(negedge clk);
    check("lat_pre", v8, 0);
    fork
      begin repeat (2) @(posedge clk); drive_tag(tagv); end
      for (int i = 0; i < 32; i++) begin @(negedge clk); check("t1_stream", v8, 1); end
    join
    @(negedge clk);
    check("t1_after", v8, 0);
    wait_drain();
    drop();
    col32 = 0;
    check("w32_count", got32.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < got32.size())
        check("w32_beat", got32[i], {i == 7, i < 4 ? ctv[i*32 +: 32] : tagv[(i-4)*32 +: 32]});
    // random backpressure, known then random vectors and tag delays
    rnd_rdy = 1;
    push_frame(ctv, tagv);
    drive_cp(ctv);
    repeat (2) @(posedge clk);
    drive_tag(tagv);
    wait_drain();
    drop();
    for (int f = 0; f < 5; f++) begin
      rc = {$urandom(), $urandom(), $urandom(), $urandom()};
      rt = {$urandom(), $urandom(), $urandom(), $urandom()};
      push_frame(rc, rt);
      if (f == 2) begin
        drive_tag(rt);
        repeat ($urandom_range(0, 10)) @(posedge clk);
        drive_cp(rc);
      end else begin
        drive_cp(rc);
        repeat ($urandom_range(0, 40)) @(posedge clk);
        drive_tag(rt);
      end
      wait_drain();
      drop();
    end
    // tag long after the ciphertext drains
    rnd_rdy = 0;
    push_frame(ctv, tagv);
    drive_cp(ctv);
    repeat (20) @(negedge clk);
    #1;
    check("wait_valid", v8, 0);
    check("wait_busy", b8, 1);
    check("wait_q", exp_q.size(), 16);
    repeat (40) @(negedge clk);
    drive_tag(tagv);
    @(negedge clk);
    check("tag_lat_pre", v8, 0);
    @(negedge clk);
    check("tag_lat", v8, 1);
    check("tag_first", d8, 8'hab);
    wait_drain();
    drop();
    // second ciphertext while busy is ignored and flagged
    push_frame(ctv, tagv);
    drive_cp(ctv);
    drop();
    repeat (3) @(posedge clk);
    drive_cp(ffv);
    check("ovr_pre", ov8, 0);
    @(posedge clk);
    @(negedge clk);
    check("ovr_set", ov8, 1);
    drive_tag(tagv);
    wait_drain();
    check("ovr_idle", b8, 0);
    check("ovr_sticky", ov8, 1);
    drop();
    // reset in the middle of the ciphertext beats
    push_frame(ctv, tagv);
    drive_cp(ctv);
    repeat (2) @(posedge clk);
    drive_tag(tagv);
    n = 0;
    while (exp_q.size() > 22 && n < 200) begin @(negedge clk); #1; n++; end
    check("t5_reach", exp_q.size(), 22);
    rst_n = 0;
    #1;
    check("mid_rst_valid", v8, 0);
    check("mid_rst_busy", b8, 0);
    check("mid_rst_ovr", ov8, 0);
    exp_q.delete();
    cp = 0;
    tg = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    rnd_rdy = 1;
    rc = {$urandom(), $urandom(), $urandom(), $urandom()};
    rt = {$urandom(), $urandom(), $urandom(), $urandom()};
    push_frame(rc, rt);
    drive_cp(rc);
    drive_tag(rt);
    wait_drain();
    check("post_rst_ovr", ov8, 0);
    drop();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
